// File: rtl/debounced_switch_logic_if.sv
// Board-pin bundle for debounced_switch_logic: raw switches and mode button in,
// result LED and mode LEDs out.
interface debounced_switch_logic_if #(
  parameter int NUM_SWITCHES = 4
);
  logic [NUM_SWITCHES-1:0] i_Switch;
  logic                    i_Mode_Btn;
  logic                    o_LED;
  logic [1:0]              o_Mode_LED;

  modport master (output i_Switch, output i_Mode_Btn, input o_LED, input o_Mode_LED);
  modport slave  (input i_Switch, input i_Mode_Btn, output o_LED, output o_Mode_LED);
endinterface

// File: rtl/debounced_switch_logic.sv
// Debounces NUM_SWITCHES switches plus a mode button, reduces the switches with a
// button-selected operator (AND/OR/XOR/NAND) and drives a registered LED.
module debounced_switch_logic_chain #(
  parameter int LIMIT = 4,
  parameter int CW    = 2
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_raw,
  output logic o_stable
);
  localparam logic [CW-1:0] CNT_MAX = CW'(LIMIT - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Counter only runs while the synchronised level disagrees with stable, so it
  // cannot wrap: it is cleared on acceptance or on any agreeing sample.
  always_comb begin
    sync1_d  = i_raw;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      stable_d = sync2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign o_stable = stable_q;
endmodule

module debounced_switch_logic #(
  parameter int NUM_SWITCHES   = 4,
  parameter int DEBOUNCE_LIMIT = 250000
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst_L,
  debounced_switch_logic_if.slave bus
);
  localparam int CW = $clog2(DEBOUNCE_LIMIT);

  typedef enum logic [1:0] {
    MODE_AND  = 2'b00,
    MODE_OR   = 2'b01,
    MODE_XOR  = 2'b10,
    MODE_NAND = 2'b11
  } mode_t;

  logic [NUM_SWITCHES:0] raw;
  logic [NUM_SWITCHES:0] stable;
  logic                  btn_dly_q, btn_dly_d;
  mode_t                 mode_q, mode_d;
  logic                  led_q, led_d;

  // Top bit is the mode button; it shares the switch chain unchanged.
  assign raw = {bus.i_Mode_Btn, bus.i_Switch};

  debounced_switch_logic_chain #(
    .LIMIT (DEBOUNCE_LIMIT),
    .CW    (CW)
  ) u_chain [NUM_SWITCHES:0] (
    .i_Clk    (i_Clk),
    .i_Rst_L  (i_Rst_L),
    .i_raw    (raw),
    .o_stable (stable)
  );

  always_comb begin
    btn_dly_d = stable[NUM_SWITCHES];
    mode_d    = mode_q;
    if (stable[NUM_SWITCHES] && !btn_dly_q)
      mode_d = mode_t'(mode_q + 2'd1);
    unique case (mode_q)
      MODE_AND:  led_d =  &stable[NUM_SWITCHES-1:0];
      MODE_OR:   led_d =  |stable[NUM_SWITCHES-1:0];
      MODE_XOR:  led_d =  ^stable[NUM_SWITCHES-1:0];
      MODE_NAND: led_d = ~&stable[NUM_SWITCHES-1:0];
      default:   led_d = 1'b0;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      btn_dly_q <= 1'b0;
      mode_q    <= MODE_AND;
      led_q     <= 1'b0;
    end else begin
      btn_dly_q <= btn_dly_d;
      mode_q    <= mode_d;
      led_q     <= led_d;
    end
  end

  assign bus.o_LED      = led_q;
  assign bus.o_Mode_LED = mode_q;
endmodule

// File: tb/tb_debounced_switch_logic.sv
// Scoreboard bench: a window-based reference model predicts LED/mode each edge,
// a negedge monitor compares; directed phases plus a randomized tail.
module tb_debounced_switch_logic;
  localparam int NS = 4;
  localparam int L  = 4;

  typedef struct packed {
    logic       led;
    logic [1:0] mode;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  debounced_switch_logic_if #(.NUM_SWITCHES(NS)) dsl_if ();

  debounced_switch_logic #(
    .NUM_SWITCHES   (NS),
    .DEBOUNCE_LIMIT (L)
  ) dut (
    .i_Clk   (clk),
    .i_Rst_L (rst_n),
    .bus     (dsl_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: an input is accepted once its last L synchronised samples
  // (raw delayed by two edges) all disagree with the current stable value.
  exp_t        exp_q[$];
  logic [NS:0] dly_q[$];
  logic [NS:0] win_q[$];
  logic [NS:0] stb, new_stb, cur, s2;
  logic [1:0]  mode;
  logic        rose, all_diff;
  exp_t        e;

  function automatic logic red(input logic [NS-1:0] v, input logic [1:0] m);
    case (m)
      2'd0:    return &v;
      2'd1:    return |v;
      2'd2:    return ^v;
      default: return ~&v;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly_q.delete();
      dly_q.push_back('0);
      dly_q.push_back('0);
      win_q.delete();
      stb  = '0;
      mode = 2'd0;
      rose = 1'b0;
      exp_q.delete();
      exp_q.push_back('0);
    end else begin
      cur = {dsl_if.i_Mode_Btn, dsl_if.i_Switch};
      dly_q.push_back(cur);
      s2 = dly_q.pop_front();
      win_q.push_back(s2);
      if (win_q.size() > L) void'(win_q.pop_front());
      e.led  = red(stb[NS-1:0], mode);
      e.mode = mode + {1'b0, rose};
      mode   = e.mode;
      new_stb = stb;
      for (int b = 0; b <= NS; b++) begin
        if (win_q.size() == L) begin
          all_diff = 1'b1;
          foreach (win_q[i]) if (win_q[i][b] == stb[b]) all_diff = 1'b0;
          if (all_diff) new_stb[b] = ~stb[b];
        end
      end
      rose = new_stb[NS] & ~stb[NS];
      stb  = new_stb;
      exp_q.push_back(e);
    end
  end

  exp_t got;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      got = '{dsl_if.o_LED, dsl_if.o_Mode_LED};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL scoreboard t=%0t got led=%0b mode=%b required led=%0b mode=%b",
                 $time, got.led, got.mode, e.led, e.mode);
      end
    end
  end

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic [NS-1:0] sw, input logic btn, input int n);
    dsl_if.i_Switch   = sw;
    dsl_if.i_Mode_Btn = btn;
    hold(n);
  endtask

  task automatic check_reset_now(input string name);
    #1;
    checks++;
    if (dsl_if.o_LED !== 1'b0 || dsl_if.o_Mode_LED !== 2'b00) begin
      errors++;
      $display("FAIL %s got led=%0b mode=%b required led=0 mode=00",
               name, dsl_if.o_LED, dsl_if.o_Mode_LED);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    dsl_if.i_Switch   = '0;
    dsl_if.i_Mode_Btn = 1'b0;
    check_reset_now("reset_initial");
    hold(3);
    rst_n = 1'b1;
    // AND latency, then one switch dropping
    drive(4'b0000, 1'b0, 5);
    drive(4'b1111, 1'b0, 12);
    drive(4'b1011, 1'b0, 12);
    drive(4'b1111, 1'b0, 10);
    // glitch rejection on switch 0
    for (int i = 0; i < 10; i++) begin
      drive(4'b1110, 1'b0, 1);
      drive(4'b1111, 1'b0, 1);
    end
    for (int i = 0; i < 3; i++) begin
      drive(4'b1110, 1'b0, 3);
      drive(4'b1111, 1'b0, 4);
    end
    drive(4'b1110, 1'b0, 4);
    drive(4'b1111, 1'b0, 12);
    // mode cycling with clean presses
    drive(4'b0111, 1'b0, 10);
    for (int i = 0; i < 5; i++) begin
      drive(4'b0111, 1'b1, 10);
      drive(4'b0111, 1'b0, 10);
    end
    // bouncing press steps once
    for (int i = 0; i < 3; i++) begin
      drive(4'b0111, 1'b1, 2);
      drive(4'b0111, 1'b0, 2);
    end
    drive(4'b0111, 1'b1, 10);
    drive(4'b0111, 1'b0, 10);
    // simultaneous switch change and press from mode AND
    rst_n = 1'b0;
    check_reset_now("reset_before_simul");
    hold(2);
    rst_n = 1'b1;
    drive(4'b0111, 1'b0, 12);
    drive(4'b1111, 1'b1, 12);
    drive(4'b1111, 1'b0, 10);
    // asynchronous reset with LED high
    rst_n = 1'b0;
    check_reset_now("reset_async");
    hold(3);
    rst_n = 1'b1;
    hold(12);
    // reset in the middle of a debounce count
    drive(4'b0000, 1'b0, 12);
    drive(4'b1111, 1'b0, 4);
    rst_n = 1'b0;
    check_reset_now("reset_mid_count");
    hold(2);
    rst_n = 1'b1;
    hold(12);
    // randomized tail
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        rst_n = 1'b0;
        check_reset_now("reset_random");
        hold($urandom_range(1, 3));
        rst_n = 1'b1;
      end
      drive(4'($urandom), ($urandom_range(0, 3) == 0), $urandom_range(1, 8));
    end
    hold(12);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
